fifo_pop_engine: RTL and testbench

//   Read-side consumer for async_fifo_top, sitting in the rclk domain.
//   On a start request it pops a burst of words from the FIFO and issues pop only when the FIFO is non-empty and buffer space exists.
//   It captures rdata one cycle after each pop and forwards words downstream over a valid/ready port.
//   A 2-entry output buffer absorbs downstream back-pressure without losing data.

---
 rtl/fifo_pop_engine.sv | 151 +++++++++++++++
 tb/tb_fifo_pop_engine.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_engine.sv
// fifo_pop_engine: read-side burst consumer for async_fifo_top (rclk domain).
// Pops bursts from the FIFO into a 2-entry output buffer. The buffer drains
// downstream over a valid/ready port, so back-pressure never drops a word.
module fifo_pop_engine #(
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned BURSTLEN = 16,
  parameter int unsigned CNTWIDTH = 16
) (
  input  logic                rclk,
  input  logic                reset,
  input  logic                enable,
  input  logic                empty,
  output logic                pop,
  input  logic [DWIDTH-1:0]   rdata,
  output logic [DWIDTH-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                busy,
  output logic                burst_done,
  output logic [CNTWIDTH-1:0] pop_count
);

  localparam int unsigned    REM_W      = (BURSTLEN < 2) ? 1 : $clog2(BURSTLEN + 1);
  localparam logic [REM_W-1:0] REM_LOAD = REM_W'(BURSTLEN);
  localparam bit             CONTINUOUS = (BURSTLEN == 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_enable_d;
  logic [REM_W-1:0]      r_remaining;
  logic                  r_pend;
  logic [1:0]            r_occ;
  logic [DWIDTH-1:0]     r_buf0;
  logic [DWIDTH-1:0]     r_buf1;
  logic [CNTWIDTH-1:0]   r_pop_count;
  logic                  r_busy;
  logic                  r_burst_done;

  logic                  w_start;
  logic                  w_xfer;
  logic [1:0]            w_fill;
  logic                  w_room;
  logic                  w_burst_left;
  logic                  w_pop;

  // Pop qualification. A slot being vacated by this cycle's downstream transfer
  // counts as free, which is what allows one pop per cycle under m_ready=1.
  always_comb begin
    w_start      = enable & ~r_enable_d;
    w_xfer       = (r_occ != 2'd0) & m_ready;
    w_fill       = r_occ + {1'b0, r_pend} - {1'b0, w_xfer};
    w_room       = (w_fill < 2'd2);
    w_burst_left = CONTINUOUS | (r_remaining != '0);
    w_pop        = (r_state == S_DRAIN) & ~empty & w_room & w_burst_left;
  end

  // Next-state logic for the burst sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (CONTINUOUS) begin
          if (!enable) w_state_nxt = S_FLUSH;
        end else if (r_remaining == '0) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: if ((r_occ == 2'd0) && !r_pend) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register plus registered status flags derived from the next state.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_enable_d   <= 1'b0;
      r_busy       <= 1'b0;
      r_burst_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_enable_d   <= enable;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_burst_done <= (w_state_nxt == S_DONE);
    end
  end

  // Burst length counter, pop-pending flag and lifetime pop statistics.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      r_remaining <= '0;
      r_pend      <= 1'b0;
      r_pop_count <= '0;
    end else begin
      r_pend <= w_pop;
      if ((r_state == S_IDLE) && w_start) begin
        r_remaining <= REM_LOAD;
      end else if (w_pop && !CONTINUOUS) begin
        r_remaining <= r_remaining - REM_W'(1);
      end
      if (w_pop) r_pop_count <= r_pop_count + CNTWIDTH'(1);
    end
  end

  // Two-entry output FIFO: r_buf0 is the head, capture lands at the tail.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      r_occ  <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      case ({r_pend, w_xfer})
        2'b10: begin
          if (r_occ == 2'd0) r_buf0 <= rdata;
          else               r_buf1 <= rdata;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= rdata;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign pop        = w_pop;
  assign m_data     = r_buf0;
  assign m_valid    = (r_occ != 2'd0);
  assign busy       = r_busy;
  assign burst_done = r_burst_done;
  assign pop_count  = r_pop_count;

endmodule

// File: tb/tb_fifo_pop_engine.sv
// Bench for fifo_pop_engine: a queue-based FIFO model feeds two instances
// (BURSTLEN=16 and BURSTLEN=0); a scoreboard checks delivery order.
module tb_fifo_pop_engine;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic rclk = 1'b0;
  logic reset;
  always #5 rclk = ~rclk;

  // Instance A: BURSTLEN=16
  logic          enable, pop, m_valid, m_ready, busy, burst_done;
  logic          empty = 1'b1;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] pop_count;

  // Instance B: BURSTLEN=0 (continuous)
  logic          enable_b, pop_b, m_valid_b, busy_b, burst_done_b;
  logic          m_ready_b = 1'b1;
  logic          empty_b = 1'b1;
  logic [DW-1:0] rdata_b = '0;
  logic [DW-1:0] m_data_b;
  logic [CW-1:0] pop_count_b;

  fifo_pop_engine #(.DWIDTH(DW), .BURSTLEN(16), .CNTWIDTH(CW)) u_dut (
    .rclk(rclk), .reset(reset), .enable(enable), .empty(empty), .pop(pop),
    .rdata(rdata), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .burst_done(burst_done), .pop_count(pop_count)
  );

  fifo_pop_engine #(.DWIDTH(DW), .BURSTLEN(0), .CNTWIDTH(CW)) u_dut_b (
    .rclk(rclk), .reset(reset), .enable(enable_b), .empty(empty_b), .pop(pop_b),
    .rdata(rdata_b), .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
    .busy(busy_b), .burst_done(burst_done_b), .pop_count(pop_count_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model and statistics for instance A
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic          pop_s = 1'b0;
  logic          rand_ready = 1'b0;
  int            stream_n = 0;
  logic [DW-1:0] stream_val = '0;
  int            cyc = 0;
  int            n_pops = 0, first_pop = 0, last_pop = 0;
  int            n_xfer = 0, n_unexp = 0, viol = 0;
  int            done_cnt = 0, done_cyc = 0, last_xfer_edge = 0;

  // FIFO model and statistics for instance B
  logic [DW-1:0] fq_b[$];
  logic          pop_b_s = 1'b0;
  int            stream_b_n = 0;
  logic [DW-1:0] push_b = 8'h80;
  logic [DW-1:0] exp_b = 8'h80;
  int            n_xfer_b = 0, viol_b = 0, done_b = 0;

  // Sample DUT outputs mid-cycle; transfers sampled here occur at the next posedge.
  always @(negedge rclk) begin
    pop_s   = pop;
    pop_b_s = pop_b;
    if (pop && empty) viol++;
    if (pop_b && empty_b) viol_b++;
    if (burst_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (burst_done_b) done_b++;
    if (m_valid && m_ready) begin
      n_xfer++;
      last_xfer_edge = cyc + 1;
      if (exp_q.size() == 0) n_unexp++;
      else check("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
    if (m_valid_b && m_ready_b) begin
      n_xfer_b++;
      check("t5_data", 32'(m_data_b), 32'(exp_b));
      exp_b = exp_b + 8'd1;
    end
  end

  // FIFO read side: data appears the cycle after pop, empty is registered.
  always @(posedge rclk) begin
    cyc++;
    if (pop_s && fq.size() != 0) begin
      rdata <= fq.pop_front();
      if (n_pops == 0) first_pop = cyc;
      last_pop = cyc;
      n_pops++;
    end
    if (stream_n > 0) begin
      fq.push_back(stream_val);
      exp_q.push_back(stream_val);
      stream_val = stream_val + 8'd1;
      stream_n--;
    end
    empty <= (fq.size() == 0);
    if (pop_b_s && fq_b.size() != 0) rdata_b <= fq_b.pop_front();
    if (stream_b_n > 0) begin
      fq_b.push_back(push_b);
      push_b = push_b + 8'd1;
      stream_b_n--;
    end
    empty_b <= (fq_b.size() == 0);
  end

  task automatic cycle();
    @(posedge rclk);
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic preload(input int n, input logic [DW-1:0] base, input bit rnd);
    logic [DW-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = rnd ? DW'($urandom) : base + DW'(i);
      fq.push_back(v);
      exp_q.push_back(v);
    end
  endtask

  task automatic clear_stats();
    n_pops   = 0;
    n_xfer   = 0;
    done_cnt = 0;
  endtask

  task automatic start_burst();
    enable = 1'b0;
    cycle();
    enable = 1'b1;
    cycle();
  endtask

  task automatic wait_done(input string tag, input int budget, input bit use_b);
    int  k;
    bit  seen;
    k    = 0;
    seen = 1'b0;
    while (k < budget && !seen) begin
      cycle();
      k++;
      if (use_b ? burst_done_b : burst_done) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset    = 1'b1;
    enable   = 1'b0;
    enable_b = 1'b0;
    m_ready  = 1'b1;
    cycles(3);
    check("rst_pop",        32'(pop),        32'd0);
    check("rst_m_valid",    32'(m_valid),    32'd0);
    check("rst_m_data",     32'(m_data),     32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_burst_done", 32'(burst_done), 32'd0);
    check("rst_pop_count",  32'(pop_count),  32'd0);
    reset = 1'b0;
    cycles(2);

    // Full burst, no back-pressure
    preload(16, 8'h00, 1'b0);
    cycles(2);
    clear_stats();
    start_burst();
    wait_done("t1_done", 100, 1'b0);
    cycles(3);
    check("t1_pops",       32'(n_pops),                     32'd16);
    check("t1_consec",     32'(last_pop - first_pop),       32'd15);
    check("t1_xfers",      32'(n_xfer),                     32'd16);
    check("t1_pop_count",  32'(pop_count),                  32'd16);
    check("t1_done_lat",   32'(done_cyc - last_xfer_edge),  32'd1);
    check("t1_done_pulse", 32'(done_cnt),                   32'd1);
    check("t1_left",       32'(exp_q.size()),               32'd0);
    check("t1_busy",       32'(busy),                       32'd0);

    // Back-pressure: two pops fill the buffer, then release
    m_ready = 1'b0;
    preload(16, 8'h40, 1'b0);
    cycles(2);
    clear_stats();
    start_burst();
    cycles(20);
    check("t2_pops_held", 32'(n_pops),  32'd2);
    check("t2_pop_low",   32'(pop),     32'd0);
    check("t2_m_valid",   32'(m_valid), 32'd1);
    check("t2_head",      32'(m_data),  32'h40);
    check("t2_busy",      32'(busy),    32'd1);
    m_ready = 1'b1;
    wait_done("t2_done", 100, 1'b0);
    cycles(3);
    check("t2_pops",      32'(n_pops),       32'd16);
    check("t2_xfers",     32'(n_xfer),       32'd16);
    check("t2_pop_count", 32'(pop_count),    32'd32);
    check("t2_left",      32'(exp_q.size()), 32'd0);
    check("t2_done",      32'(done_cnt),     32'd1);

    // Underflow stall mid-burst, then writer tops up
    preload(3, 8'h60, 1'b0);
    cycles(2);
    clear_stats();
    start_burst();
    cycles(15);
    check("t3_pops_stall", 32'(n_pops),   32'd3);
    check("t3_busy",       32'(busy),     32'd1);
    check("t3_pop_low",    32'(pop),      32'd0);
    check("t3_no_done",    32'(done_cnt), 32'd0);
    check("t3_m_valid",    32'(m_valid),  32'd0);
    stream_val = 8'h63;
    stream_n   = 13;
    wait_done("t3_done", 100, 1'b0);
    cycles(3);
    check("t3_pops",      32'(n_pops),       32'd16);
    check("t3_done",      32'(done_cnt),     32'd1);
    check("t3_pop_count", 32'(pop_count),    32'd48);
    check("t3_left",      32'(exp_q.size()), 32'd0);

    // Async reset after 5 pops, then clean restart
    preload(16, 8'h80, 1'b0);
    cycles(2);
    clear_stats();
    start_burst();
    k = 0;
    while (n_pops < 5 && k < 50) begin
      cycle();
      k++;
    end
    check("t4_reach5", 32'(n_pops), 32'd5);
    reset = 1'b1;
    #1;
    check("t4_rst_pop",       32'(pop),        32'd0);
    check("t4_rst_m_valid",   32'(m_valid),    32'd0);
    check("t4_rst_pop_count", 32'(pop_count),  32'd0);
    check("t4_rst_busy",      32'(busy),       32'd0);
    check("t4_rst_done",      32'(burst_done), 32'd0);
    enable = 1'b0;
    cycles(2);
    fq.delete();
    exp_q.delete();
    cycles(2);
    reset = 1'b0;
    cycles(2);
    check("t4_idle", 32'(busy), 32'd0);
    preload(16, 8'h90, 1'b0);
    cycles(2);
    clear_stats();
    start_burst();
    wait_done("t4_restart", 100, 1'b0);
    cycles(3);
    check("t4_pops",      32'(n_pops),       32'd16);
    check("t4_pop_count", 32'(pop_count),    32'd16);
    check("t4_left",      32'(exp_q.size()), 32'd0);
    check("t4_unexp",     32'(n_unexp),      32'd0);

    // Continuous drain (BURSTLEN=0) with a streaming writer
    enable_b   = 1'b1;
    stream_b_n = 36;
    cycles(20);
    check("t5_busy_mid", 32'(busy_b), 32'd1);
    cycles(20);
    enable_b = 1'b0;
    wait_done("t5_done", 50, 1'b1);
    cycles(3);
    check("t5_xfers",     32'(n_xfer_b),    32'd36);
    check("t5_pop_count", 32'(pop_count_b), 32'd36);
    check("t5_done",      32'(done_b),      32'd1);
    check("t5_last",      32'(exp_b),       32'hA4);
    check("t5_busy",      32'(busy_b),      32'd0);
    check("t5_viol",      32'(viol_b),      32'd0);

    // Random back-pressure over 13 bursts of random words
    rand_ready = 1'b1;
    preload(208, 8'h00, 1'b1);
    cycles(2);
    clear_stats();
    for (int b = 0; b < 13; b++) begin
      start_burst();
      wait_done("t6_done", 400, 1'b0);
    end
    rand_ready = 1'b0;
    m_ready    = 1'b1;
    cycles(5);
    check("t6_xfers",     32'(n_xfer),       32'd208);
    check("t6_pops",      32'(n_pops),       32'd208);
    check("t6_left",      32'(exp_q.size()), 32'd0);
    check("t6_unexp",     32'(n_unexp),      32'd0);
    check("t6_pop_count", 32'(pop_count),    32'd224);
    check("pop_on_empty", 32'(viol),         32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
